// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, FSM state encoding and the code -> (row, col) keypad layout.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_GAP    = 2'd3
    } kp_state_t;

    // Returns {row_idx, col_idx}; row_idx is the row bit the scanner drives low,
    // col_idx the column bit the key pulls low. Row 3 is the top row "1 2 3 A".
    function automatic logic [3:0] key_row_col(input logic [3:0] code);
        logic [3:0] rc;
        case (code)
            KEY_1:    rc = {2'd3, 2'd0};
            KEY_2:    rc = {2'd3, 2'd1};
            KEY_3:    rc = {2'd3, 2'd2};
            KEY_A:    rc = {2'd3, 2'd3};
            KEY_4:    rc = {2'd2, 2'd0};
            KEY_5:    rc = {2'd2, 2'd1};
            KEY_6:    rc = {2'd2, 2'd2};
            KEY_B:    rc = {2'd2, 2'd3};
            KEY_7:    rc = {2'd1, 2'd0};
            KEY_8:    rc = {2'd1, 2'd1};
            KEY_9:    rc = {2'd1, 2'd2};
            KEY_C:    rc = {2'd1, 2'd3};
            KEY_STAR: rc = {2'd0, 2'd0};
            KEY_0:    rc = {2'd0, 2'd1};
            KEY_HASH: rc = {2'd0, 2'd2};
            default:  rc = {2'd0, 2'd3};   // KEY_D
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/keypad_key_map.sv
// keypad_key_map: key code -> one-hot row mask and one-hot column mask (active high).
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: code (4) in; row_mask (4) out; col_mask (4) out.
module keypad_key_map
    import keypad_pkg::*;
(
    input  logic [3:0] code,
    output logic [3:0] row_mask,
    output logic [3:0] col_mask
);

    logic [3:0] rc;

    always_comb begin
        rc       = key_row_col(code);
        row_mask = 4'b0001 << rc[3:2];
        col_mask = 4'b0001 << rc[1:0];
    end

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: responder side of a 4x4 row/col keypad scan; presses one key per request.
// Latency: contact closes the cycle after accept; col follows row combinationally.
// Backpressure: req_ready only in IDLE; requests while busy are simply not taken.
// Ports: clk, rst (sync, active high); row[3:0] in / col[3:0] out (both active low);
//        req_valid, req_code[3:0] in, req_ready out; abort in; busy, contact, done out.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int CNT_W         = 20,
    parameter int HOLD_CYCLES   = 400000,
    parameter int GAP_CYCLES    = 400000,
    parameter int BOUNCE_CYCLES = 0,
    parameter int BOUNCE_PERIOD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    input  logic       req_valid,
    input  logic [3:0] req_code,
    output logic       req_ready,
    input  logic       abort,
    output logic       busy,
    output logic       contact,
    output logic       done
);

    // Counters are loaded with length-1 so each phase spends exactly its length in cycles.
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BNC_LD  = CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] PER_LD  = CNT_W'(BOUNCE_PERIOD - 1);

    kp_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] bnc_cnt, bnc_cnt_nxt;
    logic             bnc_tog, bnc_tog_nxt;
    logic [3:0]       code_q, code_nxt;
    logic             done_nxt;
    logic [3:0]       row_mask, col_mask;
    logic             hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bnc_cnt <= '0;
            bnc_tog <= 1'b0;
            code_q  <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bnc_cnt <= bnc_cnt_nxt;
            bnc_tog <= bnc_tog_nxt;
            code_q  <= code_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bnc_cnt_nxt = bnc_cnt;
        bnc_tog_nxt = bnc_tog;
        code_nxt    = code_q;
        done_nxt    = 1'b0;
        contact     = 1'b0;
        req_ready   = 1'b0;

        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    code_nxt    = req_code;
                    bnc_tog_nxt = 1'b1;     // bounce always opens with the contact closed
                    bnc_cnt_nxt = PER_LD;
                    if (BOUNCE_CYCLES > 0) begin
                        state_nxt = ST_BOUNCE;
                        cnt_nxt   = BNC_LD;
                    end else begin
                        state_nxt = ST_HOLD;
                        cnt_nxt   = HOLD_LD;
                    end
                end
            end
            ST_BOUNCE: begin
                contact = bnc_tog;
                cnt_nxt = cnt - 1'b1;
                if (bnc_cnt == '0) begin
                    bnc_tog_nxt = ~bnc_tog;
                    bnc_cnt_nxt = PER_LD;
                end else begin
                    bnc_cnt_nxt = bnc_cnt - 1'b1;
                end
                // abort takes precedence over the natural end of the phase
                if (abort) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = GAP_LD;
                end else if (cnt == '0) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = HOLD_LD;
                end
            end
            ST_HOLD: begin
                contact = 1'b1;
                cnt_nxt = cnt - 1'b1;
                if (abort || cnt == '0) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = GAP_LD;
                end
            end
            default: begin   // ST_GAP
                cnt_nxt = cnt - 1'b1;
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end
            end
        endcase
    end

    assign busy = ~req_ready;

    keypad_key_map u_key_map (
        .code     (code_q),
        .row_mask (row_mask),
        .col_mask (col_mask)
    );

    // Only the mapped row being driven low closes the circuit; other low rows are irrelevant.
    assign hit = contact & |(row_mask & ~row);
    assign col = ~(col_mask & {4{hit}});

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed scenarios plus randomized traffic on two parameterizations.
// Latency: n/a. Backpressure: n/a.
// Reference model is timeline based: press/gap/done cycles computed from the accept cycle.
module tb_keypad_emulator;
    import keypad_pkg::*;

    localparam int NI = 2;
    // instance 0: no bounce; instance 1: bounce with a short period
    localparam int B0 = 0, H0 = 8, G0 = 4, P0 = 16;
    localparam int B1 = 8, H1 = 6, G1 = 3, P1 = 2;

    logic       clk;
    logic       rst_s  [NI];
    logic [3:0] row_s  [NI];
    logic       rv_s   [NI];
    logic [3:0] rc_s   [NI];
    logic       ab_s   [NI];
    logic [3:0] col_s  [NI];
    logic       rdy_s  [NI];
    logic       busy_s [NI];
    logic       ct_s   [NI];
    logic       done_s [NI];

    keypad_emulator #(.CNT_W(8), .HOLD_CYCLES(H0), .GAP_CYCLES(G0),
                      .BOUNCE_CYCLES(B0), .BOUNCE_PERIOD(P0)) dut0 (
        .clk(clk), .rst(rst_s[0]), .row(row_s[0]), .col(col_s[0]),
        .req_valid(rv_s[0]), .req_code(rc_s[0]), .req_ready(rdy_s[0]),
        .abort(ab_s[0]), .busy(busy_s[0]), .contact(ct_s[0]), .done(done_s[0]));

    keypad_emulator #(.CNT_W(8), .HOLD_CYCLES(H1), .GAP_CYCLES(G1),
                      .BOUNCE_CYCLES(B1), .BOUNCE_PERIOD(P1)) dut1 (
        .clk(clk), .rst(rst_s[1]), .row(row_s[1]), .col(col_s[1]),
        .req_valid(rv_s[1]), .req_code(rc_s[1]), .req_ready(rdy_s[1]),
        .abort(ab_s[1]), .busy(busy_s[1]), .contact(ct_s[1]), .done(done_s[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         pb [NI], ph [NI], pg [NI], pp [NI];
    int         lay [4][4];          // lay[row_idx][col_idx] = key code on that crossing
    int         n;                   // current cycle index
    bit         act    [NI];
    int         acc_n  [NI];         // cycle in which the request was accepted
    int         end_c  [NI];         // last cycle with the contact phase (bounce/hold)
    int         end_g  [NI];         // last gap cycle
    int         done_n [NI];         // cycle in which done is expected
    logic [3:0] mcode  [NI];

    logic [3:0] obs_col  [NI];
    logic       obs_done [NI];
    logic       obs_rdy  [NI];
    logic       obs_ct   [NI];

    function automatic bit in_press(input int i);
        return act[i] && n > acc_n[i] && n <= end_c[i];
    endfunction

    function automatic bit exp_contact(input int i);
        int k;
        if (!in_press(i)) return 1'b0;
        k = n - acc_n[i];
        if (k <= pb[i]) return (((k - 1) / pp[i]) % 2) == 0;
        return 1'b1;
    endfunction

    function automatic bit exp_ready(input int i);
        return !(act[i] && n > acc_n[i] && n <= end_g[i]);
    endfunction

    function automatic logic [3:0] exp_col(input int i);
        logic [3:0] c;
        c = 4'hF;
        if (exp_contact(i))
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++)
                    if (lay[r][k] == int'(mcode[i]) && row_s[i][r] == 1'b0) c[k] = 1'b0;
        return c;
    endfunction

    // One clock cycle: check outputs at negedge against the model, then advance the model
    // with the inputs that were sampled at the following posedge.
    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("col%0d", i),     32'(col_s[i]),  32'(exp_col(i)));
            check_eq($sformatf("contact%0d", i), 32'(ct_s[i]),   32'(exp_contact(i)));
            check_eq($sformatf("ready%0d", i),   32'(rdy_s[i]),  32'(exp_ready(i)));
            check_eq($sformatf("busy%0d", i),    32'(busy_s[i]), 32'(!exp_ready(i)));
            check_eq($sformatf("done%0d", i),    32'(done_s[i]), 32'(n == done_n[i]));
            obs_col[i]  = col_s[i];
            obs_done[i] = done_s[i];
            obs_rdy[i]  = rdy_s[i];
            obs_ct[i]   = ct_s[i];
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (rst_s[i]) begin
                act[i]    = 1'b0;
                done_n[i] = -1;
            end else if (exp_ready(i) && rv_s[i]) begin
                act[i]    = 1'b1;
                acc_n[i]  = n;
                end_c[i]  = n + pb[i] + ph[i];
                end_g[i]  = end_c[i] + pg[i];
                done_n[i] = end_g[i] + 1;
                mcode[i]  = rc_s[i];
            end else if (ab_s[i] && in_press(i)) begin
                end_c[i]  = n;
                end_g[i]  = n + pg[i];
                done_n[i] = end_g[i] + 1;
            end
        end
        n++;
        #1;
    endtask

    task automatic wait_done(input int i, input int max);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < max && !seen; k++) begin
            cycle();
            seen = obs_done[i];
        end
        check_eq($sformatf("done_seen%0d", i), 32'(seen), 32'd1);
    endtask

    task automatic request(input int i, input logic [3:0] code);
        rv_s[i] = 1'b1;
        rc_s[i] = code;
        cycle();
        rv_s[i] = 1'b0;
    endtask

    logic [3:0] rows [4];
    logic [7:0] pat;
    int         low_cnt, done_at, g;
    bit         hold_ok;

    initial begin
        pb = '{B0, B1}; ph = '{H0, H1}; pg = '{G0, G1}; pp = '{P0, P1};
        lay[3] = '{1, 2, 3, 10};
        lay[2] = '{4, 5, 6, 11};
        lay[1] = '{7, 8, 9, 12};
        lay[0] = '{14, 0, 15, 13};
        rows = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        for (int i = 0; i < NI; i++) begin
            rst_s[i] = 1'b1; row_s[i] = 4'hF; rv_s[i] = 1'b0; rc_s[i] = 4'h0; ab_s[i] = 1'b0;
            act[i] = 1'b0; done_n[i] = -1; acc_n[i] = 0; end_c[i] = 0; end_g[i] = 0;
            mcode[i] = 4'h0;
        end
        n = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) rst_s[i] = 1'b0;

        // reset state
        cycle();
        check_eq("rst_col0", 32'(obs_col[0]), 32'hF);
        check_eq("rst_rdy0", 32'(obs_rdy[0]), 32'd1);

        // basic press, code 5 on row 2 -> column 1
        row_s[0] = 4'b1011;
        request(0, KEY_5);
        low_cnt = 0; done_at = -1;
        for (int j = 1; j <= 16; j++) begin
            cycle();
            if (obs_col[0] == 4'b1101) low_cnt++;
            if (obs_done[0] && done_at < 0) done_at = j;
        end
        check_eq("press_len", 32'(low_cnt), 32'd8);
        // done registers on the 12th edge after the accept edge -> seen in cycle 13
        check_eq("done_lat", 32'(done_at), 32'd13);

        // sweep all codes with the scanner cycling rows
        for (int c = 0; c < 16; c++) begin
            request(0, 4'(c));
            for (int j = 0; j < 13; j++) begin
                row_s[0] = rows[j % 4];
                cycle();
            end
        end

        // corner keys on the bottom row
        row_s[0] = 4'b1110;
        request(0, KEY_STAR);
        cycle();
        check_eq("star_col", 32'(obs_col[0]), 32'b1110);
        wait_done(0, 20);
        request(0, KEY_D);
        cycle();
        check_eq("d_col", 32'(obs_col[0]), 32'b0111);
        wait_done(0, 20);

        // bounce pattern on instance 1, key 1 on the top row
        row_s[1] = 4'b0111;
        request(1, KEY_1);
        pat = 8'h00;
        for (int j = 0; j < 8; j++) begin
            cycle();
            pat[7 - j] = obs_col[1][0];
        end
        check_eq("bounce_pat", 32'(pat), 32'b00110011);
        hold_ok = 1'b1;
        for (int j = 0; j < H1; j++) begin
            cycle();
            if (obs_col[1][0] != 1'b0) hold_ok = 1'b0;
        end
        check_eq("bounce_hold", 32'(hold_ok), 32'd1);
        wait_done(1, 20);

        // abort on the 3rd hold cycle; a request during the press waits for done
        row_s[0] = 4'b1101;
        request(0, KEY_9);
        cycle();
        cycle();
        ab_s[0] = 1'b1;
        cycle();
        ab_s[0] = 1'b0;
        rv_s[0] = 1'b1;
        rc_s[0] = KEY_3;
        cycle();
        check_eq("abort_col", 32'(obs_col[0]), 32'hF);
        check_eq("abort_rdy", 32'(obs_rdy[0]), 32'd0);
        g = 1;
        while (!obs_done[0] && g < 20) begin
            cycle();
            g++;
        end
        rv_s[0] = 1'b0;
        check_eq("abort_gap", 32'(g), 32'(G0 + 1));
        check_eq("abort_done_rdy", 32'(obs_rdy[0]), 32'd1);
        wait_done(0, 20);

        // reset mid-hold, then an immediate new request
        row_s[1] = 4'b0111;
        request(1, KEY_2);
        repeat (10) cycle();
        rst_s[1] = 1'b1;
        cycle();
        rst_s[1] = 1'b0;
        rv_s[1]  = 1'b1;
        rc_s[1]  = KEY_2;
        cycle();
        rv_s[1] = 1'b0;
        check_eq("rst_mid_col", 32'(obs_col[1]), 32'hF);
        check_eq("rst_mid_rdy", 32'(obs_rdy[1]), 32'd1);
        check_eq("rst_mid_done", 32'(obs_done[1]), 32'd0);
        cycle();
        check_eq("rst_reacc_ct", 32'(obs_ct[1]), 32'd1);
        wait_done(1, 30);

        // randomized traffic on both instances
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < NI; i++) begin
                rst_s[i] = ($urandom_range(0, 255) == 0);
                rv_s[i]  = ($urandom_range(0, 3) == 0);
                rc_s[i]  = 4'($urandom);
                ab_s[i]  = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 1) == 0)
                    row_s[i] = 4'hF ^ (4'b0001 << $urandom_range(0, 3));
                else
                    row_s[i] = 4'($urandom);
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
